// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared SHA3 types, digest-size constants and lane-count helper
package sha3_pkg;

    typedef logic [63:0] lane_t;

    typedef enum logic {
        IDLE,
        EMIT
    } squeeze_state_t;

    localparam int DIGEST_224 = 224;
    localparam int DIGEST_256 = 256;
    localparam int DIGEST_384 = 384;
    localparam int DIGEST_512 = 512;

    function automatic int lanes_for(int bits);
        return (bits + 63) / 64;
    endfunction

endpackage

// File: rtl/sha3_squeeze_if.sv
// rtl/sha3_squeeze_if.sv - digest word stream between squeeze stage and host consumer
interface sha3_squeeze_if;
    logic [63:0] odata;
    logic        ovalid;
    logic        olast;
    logic        oready;

    modport master (output odata, output ovalid, output olast, input oready);
    modport slave  (input odata, input ovalid, input olast, output oready);
endinterface

// File: rtl/sha3_byteswap64.sv
// rtl/sha3_byteswap64.sv - combinational 64-bit byte reverser, exists only with SHA3_SQUEEZE_BYTESWAP_EN
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
module sha3_byteswap64 (
    input  logic [63:0] din,
    output logic [63:0] dout
);
    for (genvar k = 0; k < 8; k++) begin : g_byte
        assign dout[8*(7-k) +: 8] = din[8*k +: 8];
    end
endmodule
`endif

// File: rtl/sha3_squeeze.sv
// rtl/sha3_squeeze.sv - captures final SHA3 state and streams the digest as 64-bit words
// Optional big-endian word output with SHA3_SQUEEZE_BYTESWAP_EN.
module sha3_squeeze
    import sha3_pkg::*;
#(
    parameter int DIGEST_BITS = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  lane_t [4:0]    isa,
    input  lane_t [4:0]    isb,
    input  lane_t [4:0]    isc,
    input  lane_t [4:0]    isd,
    input  lane_t [4:0]    ise,
    input  logic           good,
    sha3_squeeze_if.master dout,
    output logic           idle,
    output logic           overrun
);
    localparam int         LANES = lanes_for(DIGEST_BITS);
    localparam logic [2:0] LAST  = 3'(LANES - 1);

    if (!(DIGEST_BITS == DIGEST_224 || DIGEST_BITS == DIGEST_256 ||
          DIGEST_BITS == DIGEST_384 || DIGEST_BITS == DIGEST_512)) begin : g_bad_bits
        $error("sha3_squeeze: illegal DIGEST_BITS %0d", DIGEST_BITS);
    end

    // Lane i = x + 5y lands at index i because isa is the least significant part.
    lane_t [24:0] lanes_all;
    logic         unused_lanes;
    assign lanes_all    = {ise, isd, isc, isb, isa};
    assign unused_lanes = ^lanes_all;

    squeeze_state_t state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic           overrun_q, overrun_d;
    logic           capture;
    logic           fire;
    lane_t          lane_buf [8];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        fire      = (state_q == EMIT) && dout.oready;
        case (state_q)
            IDLE: begin
                if (good) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (fire && idx_q == LAST) begin
                    idx_d = 3'd0;
                    if (good) capture = 1'b1;
                    else      state_d = IDLE;
                end else begin
                    if (fire) idx_d = idx_q + 3'd1;
                    if (good) overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 8; i++) lane_buf[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            if (capture) begin
                for (int i = 0; i < 8; i++) lane_buf[i] <= (i < LANES) ? lanes_all[i] : '0;
            end
        end
    end

    // The 224-bit digest only fills the low half of its last lane.
    lane_t word_raw, word_out;
    always_comb begin
        word_raw = lane_buf[idx_q];
        if (DIGEST_BITS == DIGEST_224 && idx_q == LAST) word_raw[63:32] = '0;
    end

`ifdef SHA3_SQUEEZE_BYTESWAP_EN
    sha3_byteswap64 u_byteswap (
        .din  (word_raw),
        .dout (word_out)
    );
`else
    assign word_out = word_raw;
`endif

    assign dout.ovalid = (state_q == EMIT);
    assign dout.olast  = (state_q == EMIT) && (idx_q == LAST);
    assign dout.odata  = (state_q == EMIT) ? word_out : '0;
    assign idle        = (state_q == IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sha3_squeeze.sv
// tb/tb_sha3_squeeze.sv - directed bench for sha3_squeeze (256- and 224-bit), honours SHA3_SQUEEZE_BYTESWAP_EN
module tb_sha3_squeeze;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0][63:0] isa, isb, isc, isd, ise;
    logic good, good224;
    logic idle, overrun, idle224, overrun224;

    sha3_squeeze_if bus ();
    sha3_squeeze_if bus224 ();

    sha3_squeeze #(.DIGEST_BITS(256)) dut (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .good(good), .dout(bus), .idle(idle), .overrun(overrun)
    );

    sha3_squeeze #(.DIGEST_BITS(224)) dut224 (
        .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
        .good(good224), .dout(bus224), .idle(idle224), .overrun(overrun224)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] word;
        logic        last;
    } vec_t;

    vec_t        vt [4];
    logic [63:0] dig [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] x);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*(7-k) +: 8] = x[8*k +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ord(input logic [63:0] x);
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
        return bswap(x);
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [63:0] v);
        case (i / 5)
            0: isa[i % 5] = v;
            1: isb[i % 5] = v;
            2: isc[i % 5] = v;
            3: isd[i % 5] = v;
            default: ise[i % 5] = v;
        endcase
    endtask

    // Digest lanes 0..3, the rest filled with recognisable junk that must never appear.
    task automatic load_empty();
        for (int i = 0; i < 25; i++) set_lane(i, 64'hbad0_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 4; i++) set_lane(i, dig[i]);
    endtask

    task automatic load_fill(input logic [63:0] v);
        for (int i = 0; i < 25; i++) set_lane(i, v);
    endtask

    logic pat [7];
    int   got;

    initial begin
        dig[0] = 64'h66d71ebff8c6ffa7;
        dig[1] = 64'h62d661a05647c151;
        dig[2] = 64'hfa493be44dff80f5;
        dig[3] = 64'h4a43f8804b0ad882;
        for (int k = 0; k < 4; k++) vt[k] = '{word: dig[k], last: (k == 3)};
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; good = 1'b0; good224 = 1'b0;
        bus.oready = 1'b0; bus224.oready = 1'b1;
        load_empty();
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_ovalid", 64'(bus.ovalid), 64'd0);
        chk("rst_olast", 64'(bus.olast), 64'd0);
        chk("rst_odata", bus.odata, 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // Main stream, table-driven
        bus.oready = 1'b1; good = 1'b1;
        tick();
        good = 1'b0;
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
        chk("word0_literal", bus.odata, 64'ha7ffc6f8bf1ed766);
`else
        chk("word0_literal", bus.odata, 64'h66d71ebff8c6ffa7);
`endif
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("main_data%0d", k), bus.odata, ord(vt[k].word));
            chk($sformatf("main_last%0d", k), 64'(bus.olast), 64'(vt[k].last));
            chk($sformatf("main_valid%0d", k), 64'(bus.ovalid), 64'd1);
            chk($sformatf("main_idle%0d", k), 64'(idle), 64'd0);
            tick();
        end
        chk("main_idle_after", 64'(idle), 64'd1);
        chk("main_ovalid_after", 64'(bus.ovalid), 64'd0);
        chk("main_odata_after", bus.odata, 64'd0);

        // Backpressure
        bus.oready = 1'b0; good = 1'b1;
        tick();
        good = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            bus.oready = (cyc < 7) ? pat[cyc] : 1'b1;
            chk($sformatf("bp_valid_c%0d", cyc), 64'(bus.ovalid), 64'd1);
            chk($sformatf("bp_data_c%0d", cyc), bus.odata, ord(dig[got]));
            if (bus.ovalid && bus.oready) got++;
            tick();
        end
        chk("bp_count", 64'(got), 64'd4);
        chk("bp_idle", 64'(idle), 64'd1);
        chk("bp_overrun", 64'(overrun), 64'd0);

        // Back-to-back recapture on the final handshake
        bus.oready = 1'b1; good = 1'b1;
        tick();
        good = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_a_data%0d", k), bus.odata, ord(dig[k]));
            chk($sformatf("b2b_a_idle%0d", k), 64'(idle), 64'd0);
            if (k == 3) begin
                load_fill(64'h1111111111111111);
                good = 1'b1;
            end
            tick();
        end
        good = 1'b0;
        chk("b2b_valid", 64'(bus.ovalid), 64'd1);
        chk("b2b_olast", 64'(bus.olast), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_b_data%0d", k), bus.odata, 64'h1111111111111111);
            chk($sformatf("b2b_b_idle%0d", k), 64'(idle), 64'd0);
            chk($sformatf("b2b_b_last%0d", k), 64'(bus.olast), 64'(k == 3));
            tick();
        end
        chk("b2b_idle_end", 64'(idle), 64'd1);
        load_empty();

        // Overrun: good while word 1 is pending
        good = 1'b1;
        tick();
        good = 1'b0;
        tick();
        bus.oready = 1'b0;
        load_fill(64'h2222222222222222);
        good = 1'b1;
        tick();
        good = 1'b0;
        load_empty();
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_hold_w1", bus.odata, ord(dig[1]));
        bus.oready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("ovr_data%0d", k), bus.odata, ord(dig[k]));
            tick();
        end
        chk("ovr_idle", 64'(idle), 64'd1);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Reset with word 2 pending
        good = 1'b1;
        tick();
        good = 1'b0;
        tick();
        tick();
        chk("mid_pending_w2", bus.odata, ord(dig[2]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ovalid", 64'(bus.ovalid), 64'd0);
        chk("mid_odata", bus.odata, 64'd0);
        chk("mid_idle", 64'(idle), 64'd1);
        chk("mid_overrun", 64'(overrun), 64'd0);
        good = 1'b1;
        tick();
        good = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mid_restart%0d", k), bus.odata, ord(dig[k]));
            tick();
        end
        chk("mid_idle_end", 64'(idle), 64'd1);

        // 224-bit digest: last word keeps only the low half of lane 3
        set_lane(3, 64'hdeadbeefcafef00d);
        good224 = 1'b1;
        tick();
        good224 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d224_data%0d", k), bus224.odata,
                (k == 3) ? ord(64'h00000000cafef00d) : ord(dig[k]));
            chk($sformatf("d224_last%0d", k), 64'(bus224.olast), 64'(k == 3));
            tick();
        end
        chk("d224_idle", 64'(idle224), 64'd1);
        chk("d224_overrun", 64'(overrun224), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_squeeze.md
# sha3_squeeze

Digest read-out stage at the output end of the SHA3 round pipeline. It captures the 5×5 lane state presented by the final iota stage on its one-cycle `good` pulse. It then streams the first DIGEST_BITS of that state as 64-bit words over a valid/ready handshake to the host-side consumer. It reports `idle` upstream so the permutation controller can hold off the next block until the digest has drained.

## Interface
- DIGEST_BITS, 256, digest length; legal values 224, 256, 384, 512. LANES = ceil(DIGEST_BITS/64), giving 4, 4, 6 or 8.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- isa, isb, isc, isd, ise  in  64×5 each  round state. Lane index i = x+5y: isa[x] is lanes 0–4, isb[x] is lanes 5–9, and so on. Only lanes 0..LANES-1 are used; the rest are ignored.
- good  in  1  state-valid pulse from the last round stage.
- odata  out  64  digest word.
- ovalid  out  1  odata valid.
- olast  out  1  current word is the final digest word.
- oready  in  1  consumer accepts the word when ovalid && oready.
- idle  out  1  high when no digest is pending. A `good` pulse is accepted only when idle, or on the final handshake cycle.
- overrun  out  1  sticky; cleared only by rst.

## Operation
- FSM states: IDLE and EMIT. Word counter `idx` is 3 bits wide, range 0..LANES-1.
- IDLE:
  - On `good`, register lanes 0..LANES-1 into the capture buffer, set idx=0 and go to EMIT.
- EMIT:
  - odata = buffer[idx], ovalid=1, olast=(idx==LANES-1).
  - On a handshake with idx<LANES-1: idx+1.
  - On a handshake with idx==LANES-1: go to IDLE, unless `good` is high in the same cycle. In that case recapture, set idx=0 and stay in EMIT (back-to-back digests, no bubble).
  - `good` while in EMIT without a final handshake: the new state is dropped, the buffer is unchanged and overrun is set to 1.
- DIGEST_BITS=224: the last word (lane 3) is emitted with bits [63:32] forced to 0. The low 32 bits carry digest bytes 24–27 (little-endian lane order).
- Byte order: digest byte k is bits [8(k mod 8)+7 : 8(k mod 8)] of lane k/8. Words are emitted lane-native unless byte-swap is enabled (see Configuration).
- When ovalid=0, odata is held at 0.
- rst in any state:
  - State goes to IDLE, idx to 0 and the buffer is cleared to 0.
  - Outputs: ovalid=0, olast=0, odata=0, idle=1, overrun=0.
  - A word in flight is discarded and is not completed.

## Timing
- `good` sampled high at edge n: odata/ovalid for word 0 are valid after edge n, i.e. in cycle n+1. Latency is 1 cycle.
- With oready held high, word k appears in cycle n+1+k and the full digest takes LANES cycles.
- All outputs are registered or decoded from registers. There is no combinational path from `good` or `oready` to any output.
- idle=1 in IDLE only. It drops in the cycle after capture and rises in the cycle after the final handshake (when no recapture occurs).
- ovalid stays high and odata stays stable until the handshake. Deasserting oready stalls with no loss.

## Configuration
- Macro SHA3_SQUEEZE_BYTESWAP_EN.
- Defined: odata is byte-reversed, so digest byte 8w is in odata[63:56] (big-endian, hex-print order). For 224 bits, the last word carries its valid bytes in [63:32], with [31:0] set to 0.
- Undefined: lane-native little-endian words as described above. The byte-swap network is not generated.

## Structure
- Shared package sha3_pkg holds:
  - lane_t (64-bit lane type).
  - squeeze_state_t enum {IDLE, EMIT}.
  - The function lanes_for(bits) returning ceil(bits/64).
  - Constants for the legal DIGEST_BITS values.
- The DIGEST_BITS legality check is an elaboration-time assertion.
- One sub-module, sha3_byteswap64: a combinational 64-bit byte reverser, instantiated only under SHA3_SQUEEZE_BYTESWAP_EN.

## Test plan
- SHA3-256 state of the empty message, `good` pulse, oready=1:
  - Without the macro: odata cycle 1 = 0x66d71ebff8c6ffa7 with olast=0; olast=1 on cycle 4; idle returns in cycle 5.
  - With the macro: odata cycle 1 = 0xa7ffc6f8bf1ed766.
- Backpressure: oready held low for 3 cycles after capture, then toggled 1,0,1,1. Each word is held stable while stalled, all 4 words arrive in order with none duplicated, and overrun=0.
- Back-to-back: `good` asserted in the same cycle as the final handshake, with the second state's lanes filled with 0x1111…. The next cycle shows ovalid=1, idx restarted, odata=0x1111…, and idle never rises.
- Overrun: `good` pulsed while word 1 is pending. Words 1–3 still come from the first state, overrun=1 and stays 1 until rst.
- DIGEST_BITS=224 with lane 3 = 0xdeadbeefcafef00d: the last word is 0x00000000cafef00d, with olast=1 on the 4th word.
- Reset mid-op: rst asserted with word 2 pending. The next cycle shows ovalid=0, odata=0, idle=1, overrun=0, and a fresh `good` restarts at word 0.
